alu_seq_64: RTL
===============

Name: alu_seq_64

Overview:
- Multi-cycle datapath ALU sitting directly upstream of the 64-bit Z register; its C output drives Z's 64-bit D input.
- Executes 32-bit logic, arithmetic and shift ops in one cycle.
- Executes signed multiply (radix-2 Booth) and signed divide (non-restoring) iteratively over 32 cycles.
- Handshakes with the control unit via start/busy/done so the controller asserts ZIn on done.

Parameters:
- WIDTH, 32, operand width; C is 2*WIDTH. Only 32 is required to be verified.
- ITER, 32, iteration count for MUL/DIV; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous, active-low reset.
- start  input  1  begin operation; sampled only when idle.
- op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 MUL, 10 DIV, 11 NEG, 12 NOT, 13-15 reserved.
- A  input  32  operand A / dividend / multiplicand.
- B  input  32  operand B / divisor / multiplier; shift amount is B[4:0].
- C  output  64  result to Z's D input; {HI, LO}.
- busy  output  1  high while a MUL/DIV iterates.
- done  output  1  one-cycle pulse; C is valid from this cycle onward.
- div_by_zero  output  1  pulses with done when DIV has B == 0.

Behaviour:
- Reset (clr=0, asynchronous): C=0, busy=0, done=0, div_by_zero=0, state=IDLE, iteration counter=0. Reset mid-operation aborts the operation; no done is produced.
- States:
  - IDLE -> EXEC on start for ops 0-8 and 11-15, and for DIV with B==0.
  - IDLE -> ITER on start for MUL, and for DIV with B!=0.
  - EXEC -> IDLE after 1 cycle.
  - ITER -> FIN after 32 iterations.
  - FIN -> IDLE after 1 cycle.
- Operands and op are latched at the start edge. Later changes to A, B or op do not affect the result.
- Single-cycle ops: start at edge E -> C updated and done=1 at edge E+1. C[63:32]=0 and C[31:0]=result.
  - ADD/SUB wrap mod 2^32.
  - NEG = 0-A; NOT = ~A.
  - SHR logical right shift; SHRA arithmetic right shift; SHL left shift, zero-fill.
  - ROR/ROL rotate by B[4:0]; a shift of 0 returns A unchanged.
  - Reserved ops: C=0, done pulse.
- MUL: signed 32x32 -> 64.
  - busy=1 from edge E+1 through the last ITER cycle.
  - One Booth step per cycle at edges E+1..E+32.
  - C={product} and done=1 at edge E+33; busy=0 at that same edge.
- DIV: signed, quotient truncated toward zero, remainder takes the sign of the dividend. C={remainder, quotient}. Same timing as MUL.
  - -2^31 / -1 -> quotient 0x80000000 (wrap), remainder 0.
- DIV by zero: no iteration. At edge E+1: C={A, 32'hFFFFFFFF}, done=1, div_by_zero=1.
- done and div_by_zero are high for exactly one cycle.
- C holds its value between operations and changes only on a done edge or on reset.
- start while busy, or in an EXEC/FIN cycle, is ignored; no queueing.
- start held high: a new op is accepted in the first IDLE cycle after done, so back-to-back single-cycle ops complete every 2 cycles.
- Internal accumulator is 65 bits for Booth (product plus appended bit) and 33 bits for the non-restoring partial remainder. A final remainder correction and sign fix-up happen in FIN.

Test Plan:
- MUL: A=0xFFFFFFF9 (-7), B=6, start -> done exactly 33 cycles after the start edge, C=0xFFFFFFFF_FFFFFFD6, busy high for 32 cycles. Also A=0x80000000, B=0x80000000 -> C=0x40000000_00000000.
- DIV: A=0xFFFFFFEF (-17), B=5 -> C=0xFFFFFFFE_FFFFFFFD, done at 33 cycles. Also A=0x80000000, B=0xFFFFFFFF -> C=0x00000000_80000000.
- Divide by zero: A=0x12, B=0 -> next edge C=0x00000012_FFFFFFFF, done=1, div_by_zero=1, busy never high.
- Single-cycle ops, each with done 1 cycle after start and C[63:32]=0:
  - ROR A=1, B=1 -> C=0x00000000_80000000.
  - SHRA A=0x80000000, B=4 -> 0xF8000000.
  - ADD A=0xFFFFFFFF, B=1 -> 0.
  - ROL with B=0 -> A.
- Handshake:
  - Change A/B mid-MUL; pulse start at cycle 10 of MUL -> result uses latched operands, second start ignored, single done.
  - start held high over two ADDs -> done every 2 cycles.
- Reset mid-MUL: drop clr at iteration 10 -> C=0, busy=0, no done. After release, SUB A=5, B=7 -> C=0x00000000_FFFFFFFE.

Source files
------------

// File: rtl/alu_seq_64_if.sv
// alu_seq_64_if: start/busy/done handshake plus operand and result bus between control unit and ALU.
interface alu_seq_64_if #(parameter int WIDTH = 32);
    logic               start;
    logic [3:0]         op;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2*WIDTH-1:0] C;
    logic               busy;
    logic               done;
    logic               div_by_zero;
    modport master (output start, op, A, B, input C, busy, done, div_by_zero);
    modport slave  (input start, op, A, B, output C, busy, done, div_by_zero);
endinterface

// File: rtl/alu_seq_64.sv
// alu_seq_64: single-cycle logic/arith/shift ALU with iterative Booth multiply and non-restoring divide feeding Z.
module alu_seq_64 #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input logic        clk,
    input logic        clr,
    alu_seq_64_if.slave bus
);
    localparam int W  = WIDTH;
    localparam int CW = $clog2(ITER);
    localparam int SW = $clog2(W);
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_DIV = 4'd10;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_FIN} state_t;

    state_t         r_state;
    logic [3:0]     r_op;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [2*W:0]   r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_sa;
    logic           r_sb;
    logic [2*W-1:0] r_c;
    logic           r_busy;
    logic           r_done;
    logic           r_dbz;

    logic [W-1:0]   w_abs_a;
    logic [W-1:0]   w_abs_b;
    logic           w_long;
    logic [W:0]     w_badd;
    logic [W:0]     w_bsum;
    logic [2*W:0]   w_bnext;
    logic [W:0]     w_rsh;
    logic [W:0]     w_rnew;
    logic [2*W:0]   w_dnext;
    logic [W:0]     w_rfix;
    logic [W-1:0]   w_rem;
    logic [W-1:0]   w_quo;
    logic [SW-1:0]  w_sh;
    logic [2*W-1:0] w_rot_r;
    logic [2*W-1:0] w_rot_l;
    logic [W-1:0]   w_lo;
    logic [2*W-1:0] w_res;

    // Booth uses r_acc as {hi, lo, q-1}; divide reuses it as {33-bit partial remainder, quotient}.
    always_comb begin
        w_abs_a = bus.A[W-1] ? -bus.A : bus.A;
        w_abs_b = bus.B[W-1] ? -bus.B : bus.B;
        w_long  = bus.op == OP_MUL || (bus.op == OP_DIV && bus.B != '0);
        w_badd  = r_acc[1:0] == 2'b01 ? {r_a[W-1], r_a} :
                  r_acc[1:0] == 2'b10 ? -{r_a[W-1], r_a} : '0;
        w_bsum  = {r_acc[2*W], r_acc[2*W:W+1]} + w_badd;
        w_bnext = {w_bsum, r_acc[W:1]};
        w_rsh   = {r_acc[2*W-1:W], r_acc[W-1]};
        w_rnew  = r_acc[2*W] ? w_rsh + {1'b0, r_b} : w_rsh - {1'b0, r_b};
        w_dnext = {w_rnew, r_acc[W-2:0], ~w_rnew[W]};
        w_rfix  = r_acc[2*W] ? r_acc[2*W:W] + {1'b0, r_b} : r_acc[2*W:W];
        w_rem   = r_sa ? -w_rfix[W-1:0] : w_rfix[W-1:0];
        w_quo   = (r_sa ^ r_sb) ? -r_acc[W-1:0] : r_acc[W-1:0];
        w_sh    = r_b[SW-1:0];
        w_rot_r = {r_a, r_a} >> w_sh;
        w_rot_l = {r_a, r_a} << w_sh;
        w_lo    = '0;
        case (r_op)
            4'd0:    w_lo = r_a + r_b;
            4'd1:    w_lo = r_a - r_b;
            4'd2:    w_lo = r_a & r_b;
            4'd3:    w_lo = r_a | r_b;
            4'd4:    w_lo = r_a >> w_sh;
            4'd5:    w_lo = $signed(r_a) >>> w_sh;
            4'd6:    w_lo = r_a << w_sh;
            4'd7:    w_lo = w_rot_r[W-1:0];
            4'd8:    w_lo = w_rot_l[2*W-1:W];
            4'd11:   w_lo = -r_a;
            4'd12:   w_lo = ~r_a;
            default: w_lo = '0;
        endcase
        w_res = r_op == OP_DIV ? {r_a, {W{1'b1}}} : {{W{1'b0}}, w_lo};
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_c     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_op    <= bus.op;
                    r_a     <= bus.A;
                    r_b     <= bus.op == OP_DIV ? w_abs_b : bus.B;
                    r_sa    <= bus.A[W-1];
                    r_sb    <= bus.B[W-1];
                    r_cnt   <= '0;
                    r_acc   <= bus.op == OP_MUL ? {{W{1'b0}}, bus.B, 1'b0} : {{(W+1){1'b0}}, w_abs_a};
                    r_state <= w_long ? S_ITER : S_EXEC;
                end
                S_EXEC: begin
                    r_c     <= w_res;
                    r_done  <= 1'b1;
                    r_dbz   <= r_op == OP_DIV;
                    r_state <= S_IDLE;
                end
                S_ITER: begin
                    r_busy  <= 1'b1;
                    r_acc   <= r_op == OP_MUL ? w_bnext : w_dnext;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CW'(ITER - 1)) r_state <= S_FIN;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_c     <= r_op == OP_MUL ? r_acc[2*W:1] : {w_rem, w_quo};
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.C           = r_c;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
endmodule
